// File: rtl/burst_main_memory.sv
// Multi-cycle burst main memory: one request, fixed latency,
// then BURST_LEN wrapped beats of read data or write data.
// Ports: clk, reset (async, active-low); req_valid/req_ready/
// req_write/req_addr request; wdata_valid/wdata/wdata_ready
// write beats; rdata_valid/rdata/rdata_last read beats;
// ack/resp_err completion pulse.
// Optional: define MAIN_MEM_ERR_EN to flag out-of-range
// requests with resp_err (reads return 0, writes dropped).
module burst_main_memory #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int BURST_LEN = 4,
  parameter int LATENCY   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              ack,
  output logic              resp_err
);

  localparam int OFF_W  = $clog2(DATA_W/8);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int CNT_W  = $clog2(LATENCY+1);

  localparam logic [IDX_W-1:0] LINE_MASK =
    IDX_W'(BURST_LEN-1);
  localparam logic [BEAT_W:0] BEAT_END =
    (BEAT_W+1)'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(LATENCY-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W:0]     beat_q, beat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic                ack_q, ack_d;
  logic                rerr_q, rerr_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    beat_addr;
  logic [BEAT_W-1:0]   beat_off;
  logic [DATA_W-1:0]   beat_data;
  logic [IDX_W-1:0]    req_idx;
  logic                addr_err;
  logic                unused_addr;

  assign req_idx     = req_addr[IDX_W+OFF_W-1:OFF_W];
  assign unused_addr = ^req_addr;

`ifdef MAIN_MEM_ERR_EN
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(DEPTH*(DATA_W/8));
  assign addr_err = ({1'b0, req_addr} >= LIMIT);
`else
  assign addr_err = 1'b0;
`endif

  // Beat k lands at line base | ((start + k) mod BURST_LEN).
  assign beat_off  = idx_q[BEAT_W-1:0] + beat_q[BEAT_W-1:0];
  assign beat_addr = (idx_q & ~LINE_MASK) | IDX_W'(beat_off);
  assign beat_data = err_q ? '0 : mem_q[beat_addr];

  assign req_ready   = (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WBURST) &&
                       (beat_q != BEAT_END);
  assign rdata_valid = rvalid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rlast_q;
  assign ack         = ack_q;
  assign resp_err    = rerr_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    ack_d    = 1'b0;
    rerr_d   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          idx_d   = req_idx;
          write_d = req_write;
          err_d   = addr_err;
          cnt_d   = CNT_LOAD;
          beat_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d = S_WBURST;
          end else begin
            // First beat is registered on this edge so it
            // appears the cycle after the wait ends.
            state_d  = S_RBURST;
            rdata_d  = beat_data;
            rvalid_d = 1'b1;
            beat_d   = beat_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RBURST: begin
        if (beat_q == BEAT_END) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          rerr_d  = err_q;
        end else begin
          rdata_d  = beat_data;
          rvalid_d = 1'b1;
          rlast_d  = (beat_q == BEAT_END - 1'b1);
          beat_d   = beat_q + 1'b1;
        end
      end
      S_WBURST: begin
        if (beat_q == BEAT_END) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          rerr_d  = err_q;
        end else if (wdata_valid) begin
          mem_we = !err_q;
          beat_d = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      ack_q    <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      ack_q    <= ack_d;
      rerr_q   <= rerr_d;
    end
  end

  // Reset reloads every word with its own index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (mem_we) begin
      mem_q[beat_addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_burst_main_memory.sv
// Self-checking bench for burst_main_memory (default params).
// Table reads, hand sequences and a random model-checked mix.
module tb_burst_main_memory;

  localparam int LAT = 3;
  localparam int BL  = 4;
  localparam int DEP = 256;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic        wdata_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        ack;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [DEP];

  typedef logic [3:0][31:0] beats_t;

  typedef struct {
    logic [31:0] addr;
    beats_t      exp;
    bit          err;
  } rvec_t;

  burst_main_memory dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .wdata_valid (wdata_valid),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .rdata_last  (rdata_last),
    .ack         (ack),
    .resp_err    (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  function automatic beats_t mk(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic [31:0] c,
                                input logic [31:0] d);
    beats_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef MAIN_MEM_ERR_EN
    return a >= DEP * 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a,
                              input int k);
    int idx;
    idx = int'((a >> 2) % DEP);
    return (idx / BL) * BL + (idx % BL + k) % BL;
  endfunction

  function automatic beats_t model_read(input logic [31:0] a);
    beats_t r;
    for (int k = 0; k < BL; k++) begin
      r[k] = is_err(a) ? 32'h0 : model[widx(a, k)];
    end
    return r;
  endfunction

  task automatic model_init();
    for (int i = 0; i < DEP; i++) model[i] = i;
  endtask

  task automatic do_reset();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    reset       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  // Returns at the accepting rising edge.
  task automatic issue(input logic [31:0] a, input bit w);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accept", 32'(got), 32'd1);
    @(posedge clk);
  endtask

  // Called at the accepting edge; checks cycles T+1..T+LAT+BL+2.
  task automatic check_read(input beats_t exp,
                            input bit err,
                            input bit keep,
                            input logic [31:0] nxt);
    int last_c;
    last_c = LAT + BL + 2;
    for (int c = 1; c <= last_c; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      if (c == 1) begin
        if (keep) req_addr = nxt;
        else req_valid = 1'b0;
      end
      chk("rd_valid", 32'(rdata_valid),
          32'((c > LAT) && (c <= LAT + BL)));
      if (c > LAT && c <= LAT + BL)
        chk("rd_data", rdata, exp[c-LAT-1]);
      if (c > LAT + BL)
        chk("rd_hold", rdata, exp[BL-1]);
      chk("rd_last", 32'(rdata_last),
          32'(c == LAT + BL));
      chk("rd_ack", 32'(ack), 32'(c == LAT + BL + 1));
      if (c == LAT + BL + 1)
        chk("rd_err", 32'(resp_err), 32'(err));
      chk("rd_ready", 32'(req_ready), 32'(c == last_c));
      chk("rd_wready", 32'(wdata_ready), 32'd0);
    end
  endtask

  task automatic do_read(input logic [31:0] a,
                         input beats_t exp,
                         input bit err);
    issue(a, 1'b0);
    check_read(exp, err, 1'b0, 32'h0);
  endtask

  // stall[b] inserts one idle cycle after beat b.
  task automatic do_write(input logic [31:0] a,
                          input beats_t d,
                          input logic [3:0] stall);
    issue(a, 1'b1);
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      if (c == 1) req_valid = 1'b0;
      wdata_valid = 1'b1;
      wdata       = $urandom;
      chk("wr_wait_rdy", 32'(wdata_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("wr_ready_on", 32'(wdata_ready), 32'd1);
    for (int b = 0; b < BL; b++) begin
      wdata_valid = 1'b1;
      wdata       = d[b];
      @(posedge clk);
      #1;
      if (!is_err(a)) model[widx(a, b)] = d[b];
      if (stall[b] && b < BL - 1) begin
        wdata_valid = 1'b0;
        wdata       = ~d[b];
        chk("wr_stall_rdy", 32'(wdata_ready), 32'd1);
        @(posedge clk);
        #1;
      end
    end
    wdata_valid = 1'b0;
    chk("wr_ready_off", 32'(wdata_ready), 32'd0);
    chk("wr_ack_early", 32'(ack), 32'd0);
    @(posedge clk);
    #1;
    chk("wr_ack", 32'(ack), 32'd1);
    chk("wr_err", 32'(resp_err), 32'(is_err(a)));
    @(posedge clk);
    #1;
    chk("wr_ack_off", 32'(ack), 32'd0);
    chk("wr_idle", 32'(req_ready), 32'd1);
  endtask

  rvec_t  tbl [5];
  beats_t e;
  beats_t d;

  initial begin
    tbl[0] = '{32'h008, mk(2, 3, 0, 1), 1'b0};
    tbl[1] = '{32'h000, mk(0, 1, 2, 3), 1'b0};
    tbl[2] = '{32'h03C, mk(15, 12, 13, 14), 1'b0};
    tbl[3] = '{32'h3FD, mk(255, 252, 253, 254), 1'b0};
`ifdef MAIN_MEM_ERR_EN
    tbl[4] = '{32'h400, mk(0, 0, 0, 0), 1'b1};
`else
    tbl[4] = '{32'h400, mk(0, 1, 2, 3), 1'b0};
`endif

    do_reset();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_wready", 32'(wdata_ready), 32'd0);
    chk("rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("rst_rlast", 32'(rdata_last), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    foreach (tbl[i]) do_read(tbl[i].addr, tbl[i].exp, tbl[i].err);

    d = mk(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    do_write(32'h14, d, 4'b0010);
    do_read(32'h10, mk(32'hA3, 32'hA0, 32'hA1, 32'hA2), 1'b0);

    d = mk(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    do_write(32'h1C, d, 4'b0000);
    do_read(32'h10, mk(32'hD1, 32'hD2, 32'hD3, 32'hD0), 1'b0);

    // Second request held through a busy burst.
    issue(32'h08, 1'b0);
    check_read(mk(2, 3, 0, 1), 1'b0, 1'b1, 32'h30);
    @(posedge clk);
    check_read(mk(12, 13, 14, 15), 1'b0, 1'b0, 32'h0);

    // Reset mid write burst after two beats.
    issue(32'h10, 1'b1);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wdata_ready) break;
    end
    chk("mid_wready", 32'(wdata_ready), 32'd1);
    for (int b = 0; b < 2; b++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hBEEF0000 + b;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_wready_off", 32'(wdata_ready), 32'd0);
    chk("mid_rvalid", 32'(rdata_valid), 32'd0);
    chk("mid_rlast", 32'(rdata_last), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    chk("mid_err", 32'(resp_err), 32'd0);
    chk("mid_rdata", rdata, 32'd0);
    wdata_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_init();
    do_read(32'h10, mk(4, 5, 6, 7), 1'b0);

    // Random mix against the array model.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BL; k++) d[k] = $urandom;
        do_write(a, d, 4'($urandom));
      end else begin
        e = model_read(a);
        do_read(a, e, is_err(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_main_memory.md
Name: burst_main_memory

Overview:
- Parametrised multi-cycle main-memory model that backs the cache controller for line refills and write-backs.
- Accepts one request per handshake and waits a fixed access latency.
- Then streams a burst of BURST_LEN beats as read data, or accepts BURST_LEN beats of write data.
- Starts at the requested (critical) word and wraps within the aligned line.

Parameters:
- DATA_W, 32: beat/word width in bits; multiple of 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 256: number of words; power of 2.
- BURST_LEN, 4: beats per line; power of 2, ≥2, ≤DEPTH.
- LATENCY, 3: wait cycles between request acceptance and first data beat; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  byte address of the critical word.
- wdata_valid  in  1  write beat present.
- wdata  in  DATA_W  write beat data.
- wdata_ready  out  1  block accepting write beats.
- rdata_valid  out  1  read beat valid; no backpressure.
- rdata  out  DATA_W  read beat data.
- rdata_last  out  1  final read beat of burst.
- ack  out  1  one-cycle pulse when the burst completes.
- resp_err  out  1  error flag, valid with ack.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-low.
- Reset values:
  - memory[i] = i.
  - req_ready = 1.
  - wdata_ready, rdata_valid, rdata_last, ack, resp_err = 0.
  - rdata = 0.
  - State IDLE.
- Addressing:
  - OFF_W = log2(DATA_W/8); IDX_W = log2(DEPTH); BEAT_W = log2(BURST_LEN).
  - word index = req_addr[IDX_W+OFF_W-1:OFF_W]; low OFF_W bits are ignored.
  - Line base = index with its low BEAT_W bits cleared. Start beat = index low BEAT_W bits.
  - Beat k (0..BURST_LEN-1) targets base | ((start + k) mod BURST_LEN), i.e. wrap within the line.
- Address and type (req_addr, req_write) are latched at acceptance.
- States:
  - IDLE: req_ready = 1. req_valid & req_ready in cycle T → WAIT, latency counter loaded.
  - WAIT: req_ready = 0. Counts LATENCY cycles, then → RBURST (read) or WBURST (write).
  - RBURST:
    - rdata_valid = 1 in cycles T+LATENCY+1 … T+LATENCY+BURST_LEN, one beat per cycle, back-to-back.
    - rdata_last = 1 on the final beat.
    - Then → DONE.
  - WBURST:
    - wdata_ready = 1.
    - Each cycle with wdata_valid writes wdata to the current beat address and advances the beat counter.
    - wdata_valid = 0 stalls with no write.
    - After the BURST_LEN-th accepted beat, wdata_ready drops the next cycle → DONE.
  - DONE: ack = 1 for exactly one cycle (resp_err valid here) → IDLE. req_ready returns to 1 the cycle after ack.
- Registered outputs:
  - rdata holds its last value when rdata_valid = 0.
  - A read ack follows the last beat by exactly one cycle: read round-trip ack = T+LATENCY+BURST_LEN+1.
- Request handling:
  - req_valid while busy is ignored (not queued); the requester must hold it.
  - wdata_valid outside WBURST is ignored.
- Read-after-write through a completed burst returns the new data.
- Reset asserted mid-burst:
  - Immediately returns to IDLE with reset output values.
  - Memory is re-initialised to index values; partial writes are discarded.

Optional Feature:
- Macro: MAIN_MEM_ERR_EN.
- Defined:
  - A request whose req_addr ≥ DEPTH*(DATA_W/8) sets resp_err = 1 with ack.
  - Read beats return 0.
  - Write beats are accepted but not stored.
  - Timing is unchanged.
- Undefined:
  - Upper address bits are ignored (aliasing).
  - resp_err is tied 0.

Test Plan:
- Defaults (DATA_W=32, DEPTH=256, BURST_LEN=4, LATENCY=3), reset released, read addr 0x08 accepted cycle T:
  - rdata 2,3,0,1 on cycles T+4…T+7.
  - rdata_last at T+7.
  - ack at T+8.
  - req_ready = 1 at T+9.
- Write addr 0x14 with beats A0,A1,A2,A3 and one wdata_valid=0 stall after A1:
  - Words 5,6,7,4 = A0..A3.
  - ack 2 cycles after the last beat.
  - Read addr 0x10 then returns A3,A0,A1,A2.
- req_valid held during a read burst with a second address: ignored until IDLE; accepted the cycle after req_ready returns to 1.
- Assert reset during WBURST after 2 beats:
  - All outputs reset asynchronously.
  - Read of that line returns 4,5,6,7 (initial values).
- With MAIN_MEM_ERR_EN, read addr 0x400:
  - 4 beats of 0.
  - ack with resp_err = 1.
- Without the macro, the same read returns 0,1,2,3 (aliased) and resp_err = 0.
- Write at addr 0x1C: wrap order 7,4,5,6 verified by readback.
